pe_col_drain: RTL and testbench

- Column controller and result collector at the bottom of one systolic PE column.
- Sequences the column's mode/en: clear accumulators, compute for K plus skew cycles, then shift accumulated partial sums down the cin/cOut chain.
- Captures one 32-bit result per shift cycle from the bottom PE's cOut into a FIFO.
- Presents results downstream on a valid/ready stream; signals completion.

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_col_drain_if.sv | 24 ++
 rtl/pe_col_drain_fifo.sv | 73 +++++++
 rtl/pe_col_drain.sv | 154 +++++++++++++++
 tb/tb_pe_col_drain.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared PE column constants, mode encodings and controller states
package pe_pkg;

    localparam int DATA_W = 32;

    // Mode bus driven to every PE in a column
    localparam logic [1:0] DENDEN = 2'b00;
    localparam logic [1:0] SPADEN = 2'b01;
    localparam logic [1:0] SHIFT  = 2'b10;
    localparam logic [1:0] WAIT   = 2'b11;

    // Column controller sequence; SHIFT prefixed to avoid clashing with the mode constant
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COMPUTE,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } col_state_t;

endpackage

// File: rtl/pe_col_drain_if.sv
// rtl/pe_col_drain_if.sv - result stream leaving the bottom of a PE column
interface pe_col_drain_if;
    import pe_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/pe_col_drain_fifo.sv
// rtl/pe_col_drain_fifo.sv - synchronous result FIFO carrying a last tag per entry
module drain_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] last_mem;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;

    // Head is forced to zero when empty so flushed or stale entries never leak out
    assign head_data = empty ? '0 : data_mem[rd_ptr];
    assign head_last = !empty && last_mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Pointer and occupancy bookkeeping; reset flushes the queue
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents are only visible through the occupancy-gated head
    always_ff @(posedge clock) begin
        if (do_push) begin
            data_mem[wr_ptr] <= push_data;
            last_mem[wr_ptr] <= push_last;
        end
    end

endmodule

// File: rtl/pe_col_drain.sv
// rtl/pe_col_drain.sv - column sequencer and result collector under one systolic PE column
module pe_col_drain
    import pe_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int KW   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [KW-1:0]     cfg_k,
    input  logic              cfg_sparse,
    output logic              pe_en,
    output logic [1:0]        pe_mode,
    output logic              pe_mode_nzet,
    output logic [DATA_W-1:0] top_cin,
    input  logic [DATA_W-1:0] col_c_in,
    pe_col_drain_if.master    res,
    output logic              busy,
    output logic              done
);

    // Holds the longest COMPUTE phase, (2^KW-1)+ROWS-1, without wrapping
    localparam int CW  = KW + $clog2(ROWS) + 1;
    localparam int FCW = $clog2(ROWS + 1);

    col_state_t     state_q;
    col_state_t     state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [KW-1:0]  k_q;
    logic [KW-1:0]  k_d;
    logic           sparse_q;
    logic           sparse_d;
    logic [CW-1:0]  compute_last;

    logic           push;
    logic           push_last;
    logic           pop;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;

    // Final COMPUTE cycle index: k + ROWS - 1 cycles counted from zero
    assign compute_last = CW'(k_q) + CW'(ROWS - 1) - CW'(1);

    assign top_cin = '0;
    assign pop     = res.out_valid && res.out_ready;

    // State, phase counter and latched tile configuration
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            sparse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            sparse_q <= sparse_d;
        end
    end

    // Next-state sequencing and Moore decode of PE controls, FIFO push and status
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        k_d          = k_q;
        sparse_d     = sparse_q;
        push         = 1'b0;
        push_last    = 1'b0;
        pe_en        = 1'b0;
        pe_mode      = WAIT;
        pe_mode_nzet = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    k_d      = cfg_k;
                    sparse_d = cfg_sparse;
                    state_d  = ST_CLEAR;
                end
            end

            // pe_en low for one edge zeroes every PE register in the column
            ST_CLEAR: begin
                state_d = (k_q == '0) ? ST_SHIFT : ST_COMPUTE;
            end

            ST_COMPUTE: begin
                pe_en        = 1'b1;
                pe_mode      = sparse_q ? SPADEN : DENDEN;
                pe_mode_nzet = sparse_q;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == compute_last) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            // Each edge captures the bottom PE while the column shifts down;
            // the final capture is row 0 and closes the tile
            ST_SHIFT: begin
                pe_en     = 1'b1;
                pe_mode   = SHIFT;
                push      = 1'b1;
                push_last = (cnt_q == CW'(ROWS - 1));
                cnt_d     = cnt_q + CW'(1);
                if (push_last) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end

            // Leave as the final entry is accepted so done follows the last pop directly
            ST_DRAIN: begin
                if (fifo_empty || (fifo_count == FCW'(1) && pop)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    drain_fifo #(
        .DEPTH (ROWS),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (col_c_in),
        .push_last (push_last),
        .pop       (pop),
        .head_data (res.out_data),
        .head_last (res.out_last),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign res.out_valid = !fifo_empty;

endmodule

// File: tb/tb_pe_col_drain.sv
// tb/tb_pe_col_drain.sv - randomized scoreboard bench for pe_col_drain with a behavioural PE column
module tb_pe_col_drain;

    localparam int ROWS = 4;
    localparam int KW   = 16;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [KW-1:0] cfg_k;
    logic          cfg_sparse;
    logic          pe_en;
    logic [1:0]    pe_mode;
    logic          pe_mode_nzet;
    logic [31:0]   top_cin;
    logic [31:0]   col_c_in;
    logic          busy;
    logic          done;

    pe_col_drain_if res_if();

    pe_col_drain #(.ROWS(ROWS), .KW(KW)) dut (
        .clock        (clk),
        .reset        (reset),
        .start        (start),
        .cfg_k        (cfg_k),
        .cfg_sparse   (cfg_sparse),
        .pe_en        (pe_en),
        .pe_mode      (pe_mode),
        .pe_mode_nzet (pe_mode_nzet),
        .top_cin      (top_cin),
        .col_c_in     (col_c_in),
        .res          (res_if),
        .busy         (busy),
        .done         (done)
    );

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   pol = 0;
    bit   last_pop_prev = 0;
    exp_t exp_q[$];

    logic [31:0] col [ROWS];
    int          inc [ROWS];

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural column: clear when disabled, accumulate inc per compute cycle, shift down in SHIFT
    always @(posedge clk) begin
        if (reset || !pe_en) begin
            for (int i = 0; i < ROWS; i++) col[i] <= '0;
        end else if (pe_mode == 2'b10) begin
            col[0] <= top_cin;
            for (int i = 1; i < ROWS; i++) col[i] <= col[i-1];
        end else if (pe_mode == 2'b00 || pe_mode == 2'b01) begin
            for (int i = 0; i < ROWS; i++) col[i] <= col[i] + 32'(inc[i]);
        end
    end
    assign col_c_in = col[ROWS-1];

    // Ready driver, updated just after each rising edge
    initial begin
        res_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (pol)
                0:       res_if.out_ready = 1'b1;
                1:       res_if.out_ready = 1'($urandom_range(0, 1));
                default: res_if.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each accepted beat and checks done placement
    always @(negedge clk) begin
        if (reset) begin
            last_pop_prev = 0;
        end else begin
            if (done) begin
                done_cnt++;
                check("done_after_last_pop", 32'(last_pop_prev), 32'd1);
            end
            if (res_if.out_valid && res_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", res_if.out_data, 32'hdead_beef);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", res_if.out_data, e.data);
                    check("out_last", 32'(res_if.out_last), 32'(e.last));
                end
                last_pop_prev = res_if.out_last;
            end else begin
                last_pop_prev = 0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pe_en"}, 32'(pe_en), 32'd0);
        check({tag, "_pe_mode"}, 32'(pe_mode), 32'd3);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(res_if.out_valid), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_data"}, res_if.out_data, 32'd0);
    endtask

    task automatic set_inc_random();
        for (int i = 0; i < ROWS; i++) inc[i] = int'($urandom_range(0, 4000)) - 2000;
    endtask

    // One full tile: expectations are queued up front, timeline is checked cycle by cycle
    task automatic run_tile(input int k, input bit sp, input int rpol, input int hold_after,
                            input bit poke_compute, input bit poke_done);
        int n;
        int d0;
        bit seen;
        n  = k + ROWS - 1;
        d0 = done_cnt;
        for (int r = ROWS - 1; r >= 0; r--) begin
            exp_t e;
            e.data = (k == 0) ? 32'd0 : 32'(n * inc[r]);
            e.last = (r == 0);
            exp_q.push_back(e);
        end
        @(negedge clk);
        pol        = rpol;
        start      = 1'b1;
        cfg_k      = KW'(k);
        cfg_sparse = sp;
        @(negedge clk);
        start = 1'b0;
        check("clear_pe_en", 32'(pe_en), 32'd0);
        check("clear_busy", 32'(busy), 32'd1);
        if (k > 0) begin
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                check("compute_pe_en", 32'(pe_en), 32'd1);
                check("compute_mode", 32'(pe_mode), sp ? 32'd1 : 32'd0);
                check("compute_nzet", 32'(pe_mode_nzet), 32'(sp));
                if (poke_compute && c == 0) begin
                    start = 1'b1;
                    cfg_k = KW'(9);
                end else begin
                    start = 1'b0;
                end
            end
        end
        for (int s = 0; s < ROWS; s++) begin
            @(negedge clk);
            check("shift_pe_en", 32'(pe_en), 32'd1);
            check("shift_mode", 32'(pe_mode), 32'd2);
            check("shift_nzet", 32'(pe_mode_nzet), 32'd0);
            if (s == 0) check("first_valid_latency_lo", 32'(res_if.out_valid), 32'd0);
            if (s == 1) check("first_valid_latency_hi", 32'(res_if.out_valid), 32'd1);
        end
        for (int c = 0; c < hold_after; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_if.out_valid), 32'd1);
            check("hold_pe_mode", 32'(pe_mode), 32'd3);
            if (exp_q.size() > 0) check("hold_data", res_if.out_data, exp_q[0].data);
            if (c == hold_after - 1) pol = 0;
        end
        seen = 0;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (poke_done) begin
            start = 1'b1;
            cfg_k = KW'($urandom_range(1, 5));
        end
        @(negedge clk);
        start = 1'b0;
        check("post_done_idle", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        pol = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset      = 1'b1;
        start      = 1'b0;
        cfg_k      = '0;
        cfg_sparse = 1'b0;
        for (int i = 0; i < ROWS; i++) inc[i] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_last", 32'(res_if.out_last), 32'd0);
        check("reset_nzet", 32'(pe_mode_nzet), 32'd0);
        check("top_cin", top_cin, 32'd0);

        // Dense tile k=3, always ready
        for (int i = 0; i < ROWS; i++) inc[i] = (i + 1) * 5;
        run_tile(3, 1'b0, 0, 0, 1'b0, 1'b0);

        // Same tile with backpressure held 5 cycles past SHIFT
        run_tile(3, 1'b0, 2, 5, 1'b0, 1'b0);

        // Sparse k=2 with an ignored start during COMPUTE
        set_inc_random();
        run_tile(2, 1'b1, 0, 0, 1'b1, 1'b0);

        // Reset held 3 cycles mid-COMPUTE
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        cfg_k = KW'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_compute");
        repeat (3) @(negedge clk);
        check("rst_compute_no_done", 32'(done_cnt - d0), 32'd0);

        // Reset mid-SHIFT after two captures, then a clean tile
        d0  = done_cnt;
        pol = 2;
        set_inc_random();
        @(negedge clk);
        start = 1'b1;
        cfg_k = KW'(1);
        @(negedge clk);
        start = 1'b0;
        repeat (ROWS) @(negedge clk);
        repeat (3) @(negedge clk);
        check("mid_shift_valid", 32'(res_if.out_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check_idle_outputs("rst_shift");
        pol = 0;
        repeat (6) @(negedge clk);
        check("rst_shift_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_shift_still_empty", 32'(res_if.out_valid), 32'd0);
        set_inc_random();
        run_tile(2, 1'b0, 0, 0, 1'b0, 1'b0);

        // k=0: CLEAR goes straight to SHIFT, all-zero results
        set_inc_random();
        run_tile(0, 1'b0, 0, 0, 1'b0, 1'b1);

        // Randomized tiles
        for (int t = 0; t < 10; t++) begin
            set_inc_random();
            run_tile(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1, 0,
                     1'b0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
